// File: rtl/reg_bank_reader_if.sv
// reg_bank_reader_if
//   Read-back stream between reg_bank_reader (master) and its consumer (slave).
//   Signals:
//     OUT_VALID  master->slave  word on OUT_DATA/OUT_IDX/OUT_LAST is valid
//     OUT_READY  slave->master  consumer accepts the current word
//     OUT_DATA   master->slave  snapshot word, BITWIDTH bits
//     OUT_IDX    master->slave  index of the current word, IDXW bits
//     OUT_LAST   master->slave  current word is word WORDS-1
//     OUT_PAR    master->slave  even parity of OUT_DATA (only with READBACK_PARITY_EN)
//   Optional feature macro: READBACK_PARITY_EN
interface reg_bank_reader_if #(
  parameter int BITWIDTH = 8,
  parameter int WORDS    = 4
);
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic                OUT_VALID;
  logic                OUT_READY;
  logic [BITWIDTH-1:0] OUT_DATA;
  logic [IDXW-1:0]     OUT_IDX;
  logic                OUT_LAST;
`ifdef READBACK_PARITY_EN
  logic                OUT_PAR;

  modport master (
    output OUT_VALID, OUT_DATA, OUT_IDX, OUT_LAST, OUT_PAR,
    input  OUT_READY
  );
  modport slave (
    input  OUT_VALID, OUT_DATA, OUT_IDX, OUT_LAST, OUT_PAR,
    output OUT_READY
  );
`else
  modport master (
    output OUT_VALID, OUT_DATA, OUT_IDX, OUT_LAST,
    input  OUT_READY
  );
  modport slave (
    input  OUT_VALID, OUT_DATA, OUT_IDX, OUT_LAST,
    output OUT_READY
  );
`endif
endinterface

// File: rtl/reg_bank_reader.sv
// reg_bank_reader
//   Captures a coherent snapshot of a flattened register bank on START and
//   streams it out word 0 first, one word per valid/ready handshake.
//   The live bank may keep changing while the snapshot drains.
//   Ports:
//     CLK    in   clock, all logic on posedge
//     RST    in   synchronous active-high reset
//     START  in   snapshot request, honoured only when idle
//     BANK   in   live bank, word k at [k*BITWIDTH +: BITWIDTH]
//     BUSY   out  high while a snapshot is being streamed
//     DONE   out  one-cycle pulse after the last word is accepted
//     rd     reg_bank_reader_if.master  output word stream
//   Optional feature macro: READBACK_PARITY_EN (adds rd.OUT_PAR, even parity)
module reg_bank_reader #(
  parameter int BITWIDTH = 8,
  parameter int WORDS    = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [BITWIDTH*WORDS-1:0] BANK,
  output logic                      BUSY,
  output logic                      DONE,
  reg_bank_reader_if.master         rd
);
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [0:0] {
    st_idle = 1'b0,
    st_send = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [IDXW-1:0]     idx_reg, idx_next;
  logic                done_reg, done_next;
  logic                load;
  logic [BITWIDTH-1:0] shadow_reg [WORDS];
  logic [BITWIDTH-1:0] bank_word  [WORDS];
  logic [BITWIDTH-1:0] sel_word;
  logic                is_last;
  logic                valid;

  // Split the flat bank into words so the snapshot load is a plain array copy.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_unpack
    assign bank_word[gi] = BANK[gi*BITWIDTH +: BITWIDTH];
  end

  // A one-entry array cannot be indexed by a 1-bit index cleanly.
  if (WORDS == 1) begin : g_sel_one
    assign sel_word = shadow_reg[0];
  end else begin : g_sel_many
    assign sel_word = shadow_reg[idx_reg];
  end

  assign is_last = (idx_reg == LAST_IDX);
  assign valid   = (state_reg == st_send);

  // State, index and done pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= st_idle;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      done_reg  <= done_next;
    end
  end

  // Snapshot storage; only written on an accepted START.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < WORDS; k++) shadow_reg[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < WORDS; k++) shadow_reg[k] <= bank_word[k];
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    done_next  = 1'b0;
    load       = 1'b0;
    unique case (state_reg)
      st_idle: begin
        // OUT_READY is irrelevant here; only START matters.
        if (START) begin
          load       = 1'b1;
          idx_next   = '0;
          state_next = st_send;
        end
      end
      st_send: begin
        // START is ignored while sending, including on the final transfer.
        if (rd.OUT_READY) begin
          if (is_last) begin
            state_next = st_idle;
            idx_next   = '0;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = st_idle;
        idx_next   = '0;
      end
    endcase
  end

  // Outputs come straight from registers, so they hold while stalled and
  // read as zero whenever nothing is being presented.
  assign BUSY         = valid;
  assign DONE         = done_reg;
  assign rd.OUT_VALID = valid;
  assign rd.OUT_DATA  = valid ? sel_word : '0;
  assign rd.OUT_IDX   = valid ? idx_reg : '0;
  assign rd.OUT_LAST  = valid & is_last;
`ifdef READBACK_PARITY_EN
  // OUT_DATA is already zero when not valid, so parity follows suit.
  assign rd.OUT_PAR   = ^rd.OUT_DATA;
`endif
endmodule
